mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port ram between the riscv_cpu instruction-fetch port and its
//  load/store data port. Arbitrates round-robin and sequences each access:
//  issue -> wait RD_LAT -> respond. It sits between cpu0 and ram0 in top and owns
//  ram we/addr/data_i.
// PARAMETERS
//  AW      32  address width
//  DW      32  data width
//  RD_LAT  1   ram read latency in cycles from sampled addr to valid data_o; legal 1..4
// PORTS
//  clk          in   1   system clock, rising edge
//  reset        in   1   asynchronous, active-low reset
//  if_req_i     in   1   fetch request; held with if_addr_i until if_gnt_o
//  if_addr_i    in   AW  fetch address
//  if_gnt_o     out  1   fetch request accepted this cycle
//  if_rvalid_o  out  1   one-cycle pulse, if_rdata_o valid
//  if_rdata_o   out  DW  fetched word
//  d_req_i      in   1   data request; held with d_we_i/d_addr_i/d_wdata_i until d_gnt_o
//  d_we_i       in   1   1 = write, 0 = read
//  d_addr_i     in   AW  data address
//  d_wdata_i    in   DW  write data
//  d_gnt_o      out  1   data request accepted this cycle
//  d_rvalid_o   out  1   one-cycle pulse; read data valid, or write-done ack
//  d_rdata_o    out  DW  read word; 0 on a write ack
//  ram_we_o     out  1   ram write enable
//  ram_addr_o   out  AW  ram address
//  ram_data_o   out  DW  ram write data
//  ram_data_i   in   DW  ram read data
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, last=DATA; all outputs 0, including both
//    gnt, both rvalid, both rdata, ram_we_o, ram_addr_o and ram_data_o.
//  - FSM states: IDLE, ISSUE, WAIT, RESP.
//    IDLE  -> ISSUE  when any req is granted
//    ISSUE -> RESP   on a write
//    ISSUE -> WAIT   on a read
//    WAIT  -> RESP   after RD_LAT cycles
//    RESP  -> IDLE   always
//  - Grant (IDLE only, reset high):
//    - if_gnt_o/d_gnt_o are combinational from req and the last register.
//    - Exactly one gnt is high per cycle. Never grant outside IDLE.
//  - Arbitration:
//    - One requester active: that requester wins.
//    - Both active: the requester not equal to last wins.
//    - last updates on each grant. After reset, IF wins the first tie.
//  - On the grant edge, latch source, we, addr and wdata (IF accesses are reads).
//  - ISSUE (1 cycle):
//    - ram_addr_o = latched addr.
//    - ram_we_o = latched we; it is high in this cycle only.
//    - ram_data_o = latched wdata on a write.
//  - WAIT:
//    - RD_LAT cycles, counted by a 3-bit counter; ram_addr_o is held stable.
//    - On the final WAIT cycle, register ram_data_i into the response register.
//  - RESP (1 cycle):
//    - The source's rvalid = 1; rdata = response register (0 on a write).
//    - The other port's rvalid/rdata stay 0.
//    - ram_addr_o holds its last value; ram_we_o = 0.
//  - Latency, with grant in cycle 0:
//    - Read: rvalid in cycle 2+RD_LAT; next grant possible in cycle 3+RD_LAT.
//    - Write: ram_we_o in cycle 1, ack in cycle 2, next grant in cycle 3.
//  - Request dropped before gnt: no access. Req changes after gnt are ignored until IDLE.
//  - Reset mid-access (any state): abort immediately. ram_we_o and rvalid drop
//    asynchronously; no stale response after reset release.
//  - Address is passed through unmodified: no alignment check, no wrap logic.
// TESTING
//  1. reset=0 for 3 cycles with both reqs high -> no gnt, all outputs 0.
//     Release reset -> if_gnt_o=1 in the first cycle.
//  2. RD_LAT=1, ram[0x10]=0xDEADBEEF, IF read 0x10 -> gnt cycle 0,
//     ram_addr_o=0x10 cycle 1, if_rvalid_o cycle 3 with if_rdata_o=0xDEADBEEF.
//  3. Data write 0x20<=0x12345678 -> ram_we_o high exactly cycle 1, d_rvalid_o
//     cycle 2 with d_rdata_o=0. A following data read of 0x20 returns 0x12345678.
//  4. Both reqs held for 6 accesses -> grants IF, D, IF, D, IF, D.
//     d_rvalid_o never fires for an IF access.
//  5. Assert reset during WAIT of a read -> ram_we_o and rvalid 0 at once.
//     After release: no rvalid until a new grant.
//  6. RD_LAT=3, IF read -> if_rvalid_o in cycle 5; ram_addr_o stable cycles 1-4.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core's fetch/data ports, the arbiter and the ram.
// The arbiter takes the slave view; the core/ram side takes the master view.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic          if_gnt_o;
    logic          if_rvalid_o;
    logic [DW-1:0] if_rdata_o;

    logic          d_req_i;
    logic          d_we_i;
    logic [AW-1:0] d_addr_i;
    logic [DW-1:0] d_wdata_i;
    logic          d_gnt_o;
    logic          d_rvalid_o;
    logic [DW-1:0] d_rdata_o;

    logic          ram_we_o;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_data_o;
    logic [DW-1:0] ram_data_i;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
        output d_gnt_o, d_rvalid_o, d_rdata_o,
        output ram_we_o, ram_addr_o, ram_data_o,
        input  ram_data_i
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i,
        input  d_gnt_o, d_rvalid_o, d_rdata_o,
        input  ram_we_o, ram_addr_o, ram_data_o,
        output ram_data_i
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing a single-port ram between instruction fetch
// and load/store; each access runs issue -> wait RD_LAT -> respond.
module mem_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    typedef enum logic {
        SRC_IF,
        SRC_D
    } src_t;

    localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

    state_t        r_state;
    src_t          r_last;
    src_t          r_src;
    logic          r_we;
    logic [2:0]    r_cnt;
    logic          r_ram_we;
    logic [AW-1:0] r_ram_addr;
    logic [DW-1:0] r_ram_data;
    logic          r_if_rvalid;
    logic [DW-1:0] r_if_rdata;
    logic          r_d_rvalid;
    logic [DW-1:0] r_d_rdata;

    logic w_idle;
    logic w_if_wins;
    logic w_if_gnt;
    logic w_d_gnt;

    // Fetch wins when alone, or on a tie when data went last.
    assign w_idle    = (r_state == S_IDLE) & reset;
    assign w_if_wins = bus.if_req_i & (~bus.d_req_i | (r_last == SRC_D));
    assign w_if_gnt  = w_idle & w_if_wins;
    assign w_d_gnt   = w_idle & bus.d_req_i & ~w_if_wins;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_last      <= SRC_D;
            r_src       <= SRC_IF;
            r_we        <= 1'b0;
            r_cnt       <= 3'd0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_data  <= '0;
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rvalid  <= 1'b0;
            r_d_rdata   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    unique case (1'b1)
                        w_if_gnt: begin
                            r_src      <= SRC_IF;
                            r_last     <= SRC_IF;
                            r_we       <= 1'b0;
                            r_ram_we   <= 1'b0;
                            r_ram_addr <= bus.if_addr_i;
                            r_state    <= S_ISSUE;
                        end
                        w_d_gnt: begin
                            r_src      <= SRC_D;
                            r_last     <= SRC_D;
                            r_we       <= bus.d_we_i;
                            r_ram_we   <= bus.d_we_i;
                            r_ram_addr <= bus.d_addr_i;
                            if (bus.d_we_i) begin
                                r_ram_data <= bus.d_wdata_i;
                            end
                            r_state    <= S_ISSUE;
                        end
                        default: ;
                    endcase
                end
                S_ISSUE: begin
                    r_ram_we <= 1'b0;
                    if (r_we) begin
                        // Only the data port writes; ack carries zero data.
                        r_d_rvalid <= 1'b1;
                        r_d_rdata  <= '0;
                        r_state    <= S_RESP;
                    end else begin
                        r_cnt   <= 3'd0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == LAT_M1) begin
                        r_state <= S_RESP;
                        if (r_src == SRC_IF) begin
                            r_if_rvalid <= 1'b1;
                            r_if_rdata  <= bus.ram_data_i;
                        end else begin
                            r_d_rvalid <= 1'b1;
                            r_d_rdata  <= bus.ram_data_i;
                        end
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_RESP: begin
                    r_if_rvalid <= 1'b0;
                    r_if_rdata  <= '0;
                    r_d_rvalid  <= 1'b0;
                    r_d_rdata   <= '0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.if_gnt_o    = w_if_gnt;
    assign bus.d_gnt_o     = w_d_gnt;
    assign bus.if_rvalid_o = r_if_rvalid;
    assign bus.if_rdata_o  = r_if_rdata;
    assign bus.d_rvalid_o  = r_d_rvalid;
    assign bus.d_rdata_o   = r_d_rdata;
    assign bus.ram_we_o    = r_ram_we;
    assign bus.ram_addr_o  = r_ram_addr;
    assign bus.ram_data_o  = r_ram_data;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model of arbitration, latency
// and memory contents, with behavioural rams for RD_LAT=1 and RD_LAT=3.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(32), .DW(32)) b1 ();
    mem_arbiter_if #(.AW(32), .DW(32)) b3 ();

    mem_arbiter #(.AW(32), .DW(32), .RD_LAT(1)) dut1 (
        .clk(clk), .reset(rst_n), .bus(b1)
    );
    mem_arbiter #(.AW(32), .DW(32), .RD_LAT(3)) dut3 (
        .clk(clk), .reset(rst_n), .bus(b3)
    );

    logic [31:0] ram1 [256];
    logic [31:0] ram3 [256];
    logic [31:0] ref1 [256];
    logic [31:0] ref3 [256];
    logic [31:0] p1, p3a, p3b, p3c;

    always @(posedge clk) begin
        if (b1.ram_we_o) ram1[b1.ram_addr_o[7:0]] <= b1.ram_data_o;
        p1 <= ram1[b1.ram_addr_o[7:0]];
    end
    always @(posedge clk) begin
        if (b3.ram_we_o) ram3[b3.ram_addr_o[7:0]] <= b3.ram_data_o;
        p3a <= ram3[b3.ram_addr_o[7:0]];
        p3b <= p3a;
        p3c <= p3b;
    end
    assign b1.ram_data_i = p1;
    assign b3.ram_data_i = p3c;

    int checks = 0;
    int fails  = 0;
    bit m_last;

    // Called just after a negedge with requests already driven on b1.
    task automatic run_txn(input string tag, input bit hold);
        bit ireq, dreq, src, we;
        logic [31:0] addr, wdata, exp_rd;
        int resp;
        ireq  = b1.if_req_i;
        dreq  = b1.d_req_i;
        src   = !(ireq && (!dreq || m_last));
        we    = src ? b1.d_we_i : 1'b0;
        addr  = src ? b1.d_addr_i : b1.if_addr_i;
        wdata = b1.d_wdata_i;
        #1;
        checks++;
        if ({b1.if_gnt_o, b1.d_gnt_o} !== {!src, src}) begin
            fails++;
            $display("FAIL %s gnt: got %b%b want %b%b", tag,
                     b1.if_gnt_o, b1.d_gnt_o, !src, src);
            repeat (8) @(negedge clk);
            return;
        end
        m_last = src;
        exp_rd = we ? 32'h0 : ref1[addr[7:0]];
        resp   = we ? 2 : 3;
        @(posedge clk);
        #1;
        if (src) begin
            b1.d_addr_i  = $urandom;
            b1.d_wdata_i = $urandom;
            b1.d_we_i    = 1'($urandom);
            b1.d_req_i   = hold;
        end else begin
            b1.if_addr_i = $urandom;
            b1.if_req_i  = hold;
        end
        for (int k = 1; k <= resp; k++) begin
            @(negedge clk);
            checks++;
            if ({b1.if_gnt_o, b1.d_gnt_o} !== 2'b00) begin
                fails++;
                $display("FAIL %s busy_gnt k=%0d: got %b%b want 00", tag, k,
                         b1.if_gnt_o, b1.d_gnt_o);
            end
            checks++;
            if (b1.ram_we_o !== (we && k == 1)) begin
                fails++;
                $display("FAIL %s ram_we k=%0d: got %b want %b", tag, k,
                         b1.ram_we_o, (we && k == 1));
            end
            checks++;
            if (b1.ram_addr_o !== addr) begin
                fails++;
                $display("FAIL %s ram_addr k=%0d: got %h want %h", tag, k,
                         b1.ram_addr_o, addr);
            end
            if (we && k == 1) begin
                checks++;
                if (b1.ram_data_o !== wdata) begin
                    fails++;
                    $display("FAIL %s ram_data: got %h want %h", tag,
                             b1.ram_data_o, wdata);
                end
            end
            checks++;
            if ({b1.if_rvalid_o, b1.d_rvalid_o} !==
                {(k == resp) && !src, (k == resp) && src}) begin
                fails++;
                $display("FAIL %s rvalid k=%0d: got %b%b want %b%b", tag, k,
                         b1.if_rvalid_o, b1.d_rvalid_o,
                         (k == resp) && !src, (k == resp) && src);
            end
            if (k == resp) begin
                checks++;
                if ((src ? b1.d_rdata_o : b1.if_rdata_o) !== exp_rd) begin
                    fails++;
                    $display("FAIL %s rdata: got %h want %h", tag,
                             src ? b1.d_rdata_o : b1.if_rdata_o, exp_rd);
                end
                checks++;
                if ((src ? b1.if_rdata_o : b1.d_rdata_o) !== 32'h0) begin
                    fails++;
                    $display("FAIL %s other_rdata: got %h want 0", tag,
                             src ? b1.if_rdata_o : b1.d_rdata_o);
                end
            end
        end
        if (we) ref1[addr[7:0]] = wdata;
    endtask

    task automatic test_reset;
        rst_n        = 1'b0;
        b1.if_req_i  = 1'b1;
        b1.if_addr_i = 32'h30;
        b1.d_req_i   = 1'b1;
        b1.d_we_i    = 1'b1;
        b1.d_addr_i  = 32'h31;
        b1.d_wdata_i = 32'hA5A5A5A5;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({b1.if_gnt_o, b1.d_gnt_o, b1.if_rvalid_o, b1.d_rvalid_o,
                 b1.ram_we_o} !== 5'b0) begin
                fails++;
                $display("FAIL rst_ctrl: got %b want 00000",
                         {b1.if_gnt_o, b1.d_gnt_o, b1.if_rvalid_o,
                          b1.d_rvalid_o, b1.ram_we_o});
            end
            checks++;
            if ({b1.if_rdata_o, b1.d_rdata_o, b1.ram_addr_o,
                 b1.ram_data_o} !== 128'h0) begin
                fails++;
                $display("FAIL rst_data: got %h %h %h %h want 0",
                         b1.if_rdata_o, b1.d_rdata_o, b1.ram_addr_o,
                         b1.ram_data_o);
            end
        end
        rst_n  = 1'b1;
        m_last = 1'b1;
        run_txn("first_gnt", 1'b0);
        b1.d_req_i = 1'b0;
    endtask

    task automatic test_if_read;
        @(negedge clk);
        b1.if_req_i  = 1'b1;
        b1.if_addr_i = 32'h10;
        run_txn("if_read", 1'b0);
    endtask

    task automatic test_write_read;
        @(negedge clk);
        b1.d_req_i   = 1'b1;
        b1.d_we_i    = 1'b1;
        b1.d_addr_i  = 32'h20;
        b1.d_wdata_i = 32'h12345678;
        run_txn("d_write", 1'b0);
        @(negedge clk);
        b1.d_req_i   = 1'b1;
        b1.d_we_i    = 1'b0;
        b1.d_addr_i  = 32'h20;
        run_txn("d_read", 1'b0);
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        b1.if_req_i  = 1'b1;
        b1.if_addr_i = $urandom;
        b1.d_req_i   = 1'b1;
        b1.d_we_i    = 1'($urandom);
        b1.d_addr_i  = $urandom;
        b1.d_wdata_i = $urandom;
        for (int i = 0; i < 6; i++) begin
            run_txn("b2b", 1'b1);
            @(negedge clk);
        end
        b1.if_req_i = 1'b0;
        b1.d_req_i  = 1'b0;
    endtask

    task automatic test_drop;
        @(negedge clk);
        b1.if_req_i  = 1'b1;
        b1.if_addr_i = 32'h10;
        fork
            run_txn("drop_busy", 1'b0);
            begin
                @(negedge clk);
                b1.d_req_i   = 1'b1;
                b1.d_we_i    = 1'b1;
                b1.d_addr_i  = 32'h20;
                b1.d_wdata_i = 32'h00000BAD;
                @(negedge clk);
                b1.d_req_i = 1'b0;
            end
        join
        repeat (4) begin
            @(negedge clk);
            checks++;
            if ({b1.if_gnt_o, b1.d_gnt_o, b1.ram_we_o} !== 3'b000) begin
                fails++;
                $display("FAIL drop_idle: got %b want 000",
                         {b1.if_gnt_o, b1.d_gnt_o, b1.ram_we_o});
            end
        end
        b1.d_req_i  = 1'b1;
        b1.d_we_i   = 1'b0;
        b1.d_addr_i = 32'h20;
        run_txn("drop_read", 1'b0);
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            int r;
            @(negedge clk);
            r = $urandom_range(1, 3);
            b1.if_req_i  = r[0];
            b1.d_req_i   = r[1];
            b1.if_addr_i = $urandom;
            b1.d_addr_i  = $urandom;
            b1.d_we_i    = 1'($urandom);
            b1.d_wdata_i = $urandom;
            run_txn("rand", 1'($urandom));
        end
        b1.if_req_i = 1'b0;
        b1.d_req_i  = 1'b0;
    endtask

    task automatic test_reset_mid(input bit we, input int k);
        bit pre_we, pre_rv;
        @(negedge clk);
        if (we) begin
            b1.d_req_i   = 1'b1;
            b1.d_we_i    = 1'b1;
            b1.d_addr_i  = 32'h20;
            b1.d_wdata_i = 32'hFFFF0000;
        end else begin
            b1.if_req_i  = 1'b1;
            b1.if_addr_i = 32'h10;
        end
        @(posedge clk);
        #1;
        b1.if_req_i = 1'b0;
        b1.d_req_i  = 1'b0;
        repeat (k - 1) @(posedge clk);
        #2;
        pre_we = we && (k == 1);
        pre_rv = !we && (k == 3);
        checks++;
        if ({b1.ram_we_o, b1.if_rvalid_o} !== {pre_we, pre_rv}) begin
            fails++;
            $display("FAIL abort_pre k=%0d: got %b%b want %b%b", k,
                     b1.ram_we_o, b1.if_rvalid_o, pre_we, pre_rv);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({b1.ram_we_o, b1.if_rvalid_o, b1.d_rvalid_o, b1.if_rdata_o,
             b1.ram_addr_o} !== 67'h0) begin
            fails++;
            $display("FAIL abort_async k=%0d: we=%b rv=%b%b rd=%h addr=%h",
                     k, b1.ram_we_o, b1.if_rvalid_o, b1.d_rvalid_o,
                     b1.if_rdata_o, b1.ram_addr_o);
        end
        m_last = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            checks++;
            if ({b1.if_rvalid_o, b1.d_rvalid_o, b1.if_gnt_o, b1.d_gnt_o,
                 b1.ram_we_o} !== 5'b0) begin
                fails++;
                $display("FAIL abort_after k=%0d: got %b want 00000", k,
                         {b1.if_rvalid_o, b1.d_rvalid_o, b1.if_gnt_o,
                          b1.d_gnt_o, b1.ram_we_o});
            end
        end
    endtask

    task automatic test_rdlat3(input logic [31:0] addr);
        logic [31:0] exp_rd;
        exp_rd = ref3[addr[7:0]];
        @(negedge clk);
        b3.if_req_i  = 1'b1;
        b3.if_addr_i = addr;
        #1;
        checks++;
        if ({b3.if_gnt_o, b3.d_gnt_o} !== 2'b10) begin
            fails++;
            $display("FAIL lat3 gnt: got %b%b want 10", b3.if_gnt_o, b3.d_gnt_o);
        end
        @(posedge clk);
        #1;
        b3.if_req_i  = 1'b0;
        b3.if_addr_i = $urandom;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k <= 5) begin
                checks++;
                if (b3.ram_addr_o !== addr) begin
                    fails++;
                    $display("FAIL lat3 addr k=%0d: got %h want %h", k,
                             b3.ram_addr_o, addr);
                end
            end
            checks++;
            if ({b3.if_rvalid_o, b3.d_rvalid_o} !== {k == 5, 1'b0}) begin
                fails++;
                $display("FAIL lat3 rvalid k=%0d: got %b%b want %b0", k,
                         b3.if_rvalid_o, b3.d_rvalid_o, k == 5);
            end
            if (k == 5) begin
                checks++;
                if (b3.if_rdata_o !== exp_rd) begin
                    fails++;
                    $display("FAIL lat3 rdata: got %h want %h",
                             b3.if_rdata_o, exp_rd);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: no finish by time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram1[i] = $urandom;
            ref1[i] = ram1[i];
            ram3[i] = $urandom;
            ref3[i] = ram3[i];
        end
        ram1[8'h10] = 32'hDEADBEEF;
        ref1[8'h10] = 32'hDEADBEEF;
        ram3[8'h40] = 32'hCAFEF00D;
        ref3[8'h40] = 32'hCAFEF00D;
        b1.if_req_i = 1'b0; b1.if_addr_i = '0;
        b1.d_req_i  = 1'b0; b1.d_we_i    = 1'b0;
        b1.d_addr_i = '0;   b1.d_wdata_i = '0;
        b3.if_req_i = 1'b0; b3.if_addr_i = '0;
        b3.d_req_i  = 1'b0; b3.d_we_i    = 1'b0;
        b3.d_addr_i = '0;   b3.d_wdata_i = '0;
        rst_n = 1'b0;
        m_last = 1'b1;

        test_reset;
        test_if_read;
        test_write_read;
        test_back_to_back;
        test_drop;
        test_random;
        test_reset_mid(1'b1, 1);
        test_reset_mid(1'b0, 2);
        test_reset_mid(1'b0, 3);
        test_rdlat3(32'h40);
        test_rdlat3({24'($urandom), 8'($urandom_range(0, 255))});

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
